// File: rtl/bottle_pkg.sv
// bottle_pkg -- shared types and helpers for the pill-bottling sequencer.
//   state_e    : sequencer states
//   bcd_t      : one BCD digit
//   bcd2_t     : two-digit BCD value {h, l}
//   BCD_MAX    : largest legal BCD digit
//   bcd2_inc   : two-digit BCD increment (L wraps 9->0 and carries into H)
//   cfg_valid  : setup check applied when a run is started
package bottle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SWAP,
    ST_DONE,
    ST_ALARM
  } state_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t h;
    bcd_t l;
  } bcd2_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // 99 rolls over to 00; the sequencer never increments past its limit,
  // so the rollover only keeps the function total.
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.l >= BCD_MAX) begin
      r.l = '0;
      r.h = (v.h >= BCD_MAX) ? '0 : v.h + 4'd1;
    end else begin
      r.l = v.l + 4'd1;
    end
    return r;
  endfunction

  function automatic logic cfg_valid(input bcd2_t max_v, input bcd2_t tgt_v);
    return (max_v.h <= BCD_MAX) && (max_v.l <= BCD_MAX) &&
           (tgt_v.h <= BCD_MAX) && (tgt_v.l <= BCD_MAX) &&
           (max_v != '0) && (tgt_v != '0);
  endfunction

endpackage

// File: rtl/bottle_fill_ctrl_if.sv
// bottle_fill_ctrl_if -- operator, sensor and actuator signals of the
// bottling sequencer.
//   slave  : the sequencer (consumes commands/config, drives status)
//   master : whoever drives the commands and reads the status
// Commands : start, pause, alarm_clr, pill_pulse, bottle_ready
// Config   : maxH/maxL (pills per bottle), tgtH/tgtL (bottles per run), BCD
// Status   : nowH/nowL, seqH/seqL (BCD), valve_open, conveyor_req, done,
//            alarm, cfg_err
interface bottle_fill_ctrl_if;
  import bottle_pkg::*;

  logic start;
  logic pause;
  logic alarm_clr;
  logic pill_pulse;
  logic bottle_ready;
  bcd_t maxH;
  bcd_t maxL;
  bcd_t tgtH;
  bcd_t tgtL;

  bcd_t nowH;
  bcd_t nowL;
  bcd_t seqH;
  bcd_t seqL;
  logic valve_open;
  logic conveyor_req;
  logic done;
  logic alarm;
  logic cfg_err;

  modport master (
    output start, pause, alarm_clr, pill_pulse, bottle_ready,
    output maxH, maxL, tgtH, tgtL,
    input  nowH, nowL, seqH, seqL,
    input  valve_open, conveyor_req, done, alarm, cfg_err
  );

  modport slave (
    input  start, pause, alarm_clr, pill_pulse, bottle_ready,
    input  maxH, maxL, tgtH, tgtL,
    output nowH, nowL, seqH, seqL,
    output valve_open, conveyor_req, done, alarm, cfg_err
  );

endinterface

// File: rtl/bcd2_counter.sv
// bcd2_counter -- two-digit BCD counter with synchronous clear and increment.
//   CLK, RST  : clock, asynchronous active-high reset
//   clr       : load 00 (wins over inc)
//   inc       : BCD increment
//   cmp       : value compared against the incremented count
//   q         : current count
//   inc_match : the count after one more increment would equal cmp
module bcd2_counter
  import bottle_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  clr,
  input  logic  inc,
  input  bcd2_t cmp,
  output bcd2_t q,
  output logic  inc_match
);

  bcd2_t q_inc;

  assign q_inc     = bcd2_inc(q);
  // Comparing the incremented value lets the sequencer react on the very
  // edge that lands on the limit.
  assign inc_match = (q_inc == cmp);

  // NOTE: non-blocking assignments in clocked blocks so every register sees
  // the pre-edge values of the others, independent of evaluation order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q_inc;
    end
  end

endmodule

// File: rtl/bottle_fill_ctrl.sv
// bottle_fill_ctrl -- pill-bottling line sequencer.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : bottle_fill_ctrl_if.slave (commands, BCD config, BCD counts,
//              valve/conveyor drives, done/alarm/cfg_err status)
// Parameter TIMEOUT_CYCLES : conveyor wait limit, only used when the
// BOTTLE_TIMEOUT_EN macro is defined. Without it SWAP waits indefinitely.
// All outputs are registered; they reflect the state entered at the edge.
module bottle_fill_ctrl
  import bottle_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic              CLK,
  input logic              RST,
  bottle_fill_ctrl_if.slave bus
);

  state_e state_q, state_d;
  bcd2_t  max_q, tgt_q;
  bcd2_t  max_in, tgt_in;
  bcd2_t  now_v, seq_v;
  logic   now_clr, now_inc, now_full;
  logic   seq_clr, seq_inc, seq_last;
  logic   cfg_load, cfg_err_d;
  logic   timeout;
  logic   valve_q, conv_q, done_q, alarm_q, cfg_err_q;

  assign max_in = {bus.maxH, bus.maxL};
  assign tgt_in = {bus.tgtH, bus.tgtL};

  bcd2_counter u_now (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (now_clr),
    .inc       (now_inc),
    .cmp       (max_q),
    .q         (now_v),
    .inc_match (now_full)
  );

  bcd2_counter u_seq (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (seq_clr),
    .inc       (seq_inc),
    .cmp       (tgt_q),
    .q         (seq_v),
    .inc_match (seq_last)
  );

`ifdef BOTTLE_TIMEOUT_EN
  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_inc;

  assign timer_inc = timer_q + TIMER_W'(1);
  // Expires on the TIMEOUT_CYCLES-th edge spent in SWAP.
  assign timeout   = (timer_inc == TIMER_W'(TIMEOUT_CYCLES));

  // Held at zero outside SWAP, so it always starts from zero on entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timer_q <= '0;
    end else if (state_q != ST_SWAP) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_inc;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  // NOTE: every signal driven here gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    now_clr   = 1'b0;
    now_inc   = 1'b0;
    seq_clr   = 1'b0;
    seq_inc   = 1'b0;
    cfg_load  = 1'b0;
    cfg_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          if (cfg_valid(max_in, tgt_in)) begin
            cfg_load = 1'b1;
            now_clr  = 1'b1;
            seq_clr  = 1'b1;
            state_d  = ST_FILL;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_FILL: begin
        // Pills count even while paused: the valve may still be draining.
        if (bus.pill_pulse) begin
          now_inc = 1'b1;
          if (now_full) begin
            state_d = ST_SWAP;
          end
        end
      end
      ST_SWAP: begin
        // A stray pill means the bottle is out of place: it beats the ack.
        if (bus.pill_pulse) begin
          state_d = ST_ALARM;
        end else if (bus.bottle_ready) begin
          seq_inc = 1'b1;
          now_clr = 1'b1;
          state_d = seq_last ? ST_DONE : ST_FILL;
        end else if (timeout) begin
          state_d = ST_ALARM;
        end
      end
      ST_ALARM: begin
        if (bus.alarm_clr) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      max_q     <= '0;
      tgt_q     <= '0;
      valve_q   <= 1'b0;
      conv_q    <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_load) begin
        max_q <= max_in;
        tgt_q <= tgt_in;
      end
      // Decoded from the next state so each output changes on the same
      // edge as the state it belongs to.
      valve_q   <= (state_d == ST_FILL) && !bus.pause;
      conv_q    <= (state_d == ST_SWAP);
      done_q    <= (state_d == ST_DONE);
      alarm_q   <= (state_d == ST_ALARM);
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.nowH         = now_v.h;
  assign bus.nowL         = now_v.l;
  assign bus.seqH         = seq_v.h;
  assign bus.seqL         = seq_v.l;
  assign bus.valve_open   = valve_q;
  assign bus.conveyor_req = conv_q;
  assign bus.done         = done_q;
  assign bus.alarm        = alarm_q;
  assign bus.cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// tb_bottle_fill_ctrl -- self-checking bench for bottle_fill_ctrl.
// A behavioural model keeps counts as plain integers and the run phase as a
// small mode number; a negedge process compares every DUT output against it.
// Directed sequences add literal expectations, then a randomized phase runs.
module tb_bottle_fill_ctrl;
  import bottle_pkg::*;

  localparam int unsigned TO = 5;
`ifdef BOTTLE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int MD_IDLE  = 0;
  localparam int MD_FILL  = 1;
  localparam int MD_SWAP  = 2;
  localparam int MD_DONE  = 3;
  localparam int MD_ALARM = 4;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  bottle_fill_ctrl_if bif ();

  bottle_fill_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bif)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model state
  int   m_mode, m_now, m_seq, m_max, m_tgt, m_timer;
  logic e_valve, e_cfg_err;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_mode    = MD_IDLE;
    m_now     = 0;
    m_seq     = 0;
    m_max     = 0;
    m_tgt     = 0;
    m_timer   = 0;
    e_valve   = 1'b0;
    e_cfg_err = 1'b0;
  endtask

  // Applies one clock edge's worth of rules to the model.
  task automatic model_step();
    int  mx, tg;
    bit  ok;
    e_cfg_err = 1'b0;
    if (RST) begin
      model_reset();
      return;
    end
    case (m_mode)
      MD_IDLE, MD_DONE: begin
        if (bif.start) begin
          mx = 10 * int'(bif.maxH) + int'(bif.maxL);
          tg = 10 * int'(bif.tgtH) + int'(bif.tgtL);
          ok = (bif.maxH <= 9) && (bif.maxL <= 9) && (bif.tgtH <= 9) &&
               (bif.tgtL <= 9) && (mx > 0) && (tg > 0);
          if (ok) begin
            m_max  = mx;
            m_tgt  = tg;
            m_now  = 0;
            m_seq  = 0;
            m_mode = MD_FILL;
          end else begin
            e_cfg_err = 1'b1;
          end
        end
      end
      MD_FILL: begin
        if (bif.pill_pulse) begin
          m_now++;
          if (m_now == m_max) begin
            m_mode  = MD_SWAP;
            m_timer = 0;
          end
        end
      end
      MD_SWAP: begin
        if (bif.pill_pulse) begin
          m_mode = MD_ALARM;
        end else if (bif.bottle_ready) begin
          m_seq++;
          m_now  = 0;
          m_mode = (m_seq == m_tgt) ? MD_DONE : MD_FILL;
        end else begin
          m_timer++;
          if (TO_EN && m_timer == int'(TO)) m_mode = MD_ALARM;
        end
      end
      MD_ALARM: begin
        if (bif.alarm_clr) m_mode = MD_IDLE;
      end
      default: m_mode = MD_IDLE;
    endcase
    e_valve = (m_mode == MD_FILL) && !bif.pause;
  endtask

  // Compare process: every output, every cycle, on the falling edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("valve_open",   8'(bif.valve_open),   8'(e_valve));
      check("conveyor_req", 8'(bif.conveyor_req), 8'(m_mode == MD_SWAP));
      check("done",         8'(bif.done),         8'(m_mode == MD_DONE));
      check("alarm",        8'(bif.alarm),        8'(m_mode == MD_ALARM));
      check("cfg_err",      8'(bif.cfg_err),      8'(e_cfg_err));
      check("now",          {bif.nowH, bif.nowL}, bcd8(m_now));
      check("seq",          {bif.seqH, bif.seqL}, bcd8(m_seq));
    end
  end

  // One clock: model follows the edge, inputs may change 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic set_cfg(input bcd_t mh, input bcd_t ml, input bcd_t th, input bcd_t tl);
    bif.maxH = mh;
    bif.maxL = ml;
    bif.tgtH = th;
    bif.tgtL = tl;
  endtask

  task automatic pill();
    bif.pill_pulse = 1'b1;
    tick();
    bif.pill_pulse = 1'b0;
  endtask

  task automatic ack();
    bif.bottle_ready = 1'b1;
    tick();
    bif.bottle_ready = 1'b0;
  endtask

  task automatic start_run();
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valve"}, 8'(bif.valve_open), 8'h00);
    check({tag, " conv"},  8'(bif.conveyor_req), 8'h00);
    check({tag, " done"},  8'(bif.done), 8'h00);
    check({tag, " alarm"}, 8'(bif.alarm), 8'h00);
    check({tag, " now"},   {bif.nowH, bif.nowL}, 8'h00);
    check({tag, " seq"},   {bif.seqH, bif.seqL}, 8'h00);
  endtask

  initial begin
    RST              = 1'b1;
    bif.start        = 1'b0;
    bif.pause        = 1'b0;
    bif.alarm_clr    = 1'b0;
    bif.pill_pulse   = 1'b0;
    bif.bottle_ready = 1'b0;
    set_cfg(4'd0, 4'd0, 4'd0, 4'd0);
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("reset");
    check("reset cfg_err", 8'(bif.cfg_err), 8'h00);
    RST    = 1'b0;
    chk_en = 1'b1;

    // max=03, tgt=02: two full bottles
    set_cfg(4'd0, 4'd3, 4'd0, 4'd2);
    start_run();
    check("start valve", 8'(bif.valve_open), 8'h01);
    pill();
    check("now 1", {bif.nowH, bif.nowL}, 8'h01);
    pill();
    check("now 2", {bif.nowH, bif.nowL}, 8'h02);
    pill();
    check("now 3", {bif.nowH, bif.nowL}, 8'h03);
    check("swap conv", 8'(bif.conveyor_req), 8'h01);
    check("swap valve", 8'(bif.valve_open), 8'h00);
    ack();
    check("seq 01", {bif.seqH, bif.seqL}, 8'h01);
    check("refill valve", 8'(bif.valve_open), 8'h01);
    repeat (3) pill();
    ack();
    check("seq 02", {bif.seqH, bif.seqL}, 8'h02);
    check("done", 8'(bif.done), 8'h01);
    check("done valve", 8'(bif.valve_open), 8'h00);

    // max=12: carry from L into H
    set_cfg(4'd1, 4'd2, 4'd0, 4'd1);
    start_run();
    check("restart done", 8'(bif.done), 8'h00);
    repeat (10) pill();
    check("now carry", {bif.nowH, bif.nowL}, 8'h10);
    pill();
    check("pill 11 valve", 8'(bif.valve_open), 8'h01);
    pill();
    check("pill 12 valve", 8'(bif.valve_open), 8'h00);
    check("pill 12 conv", 8'(bif.conveyor_req), 8'h01);
    ack();

    // Stray pill with ack in the same cycle
    set_cfg(4'd0, 4'd1, 4'd0, 4'd3);
    start_run();
    pill();
    bif.bottle_ready = 1'b1;
    pill();
    bif.bottle_ready = 1'b0;
    check("stray alarm", 8'(bif.alarm), 8'h01);
    check("stray seq", {bif.seqH, bif.seqL}, 8'h00);
    start_run();
    check("alarm ignores start", 8'(bif.alarm), 8'h01);
    bif.alarm_clr = 1'b1;
    tick();
    bif.alarm_clr = 1'b0;
    check("alarm cleared", 8'(bif.alarm), 8'h00);

    // Invalid setups from IDLE
    set_cfg(4'd0, 4'd0, 4'd0, 4'd1);
    start_run();
    check("max00 cfg_err", 8'(bif.cfg_err), 8'h01);
    check("max00 valve", 8'(bif.valve_open), 8'h00);
    tick();
    check("cfg_err one cycle", 8'(bif.cfg_err), 8'h00);
    set_cfg(4'd0, 4'd2, 4'd0, 4'hA);
    start_run();
    check("tgtA cfg_err", 8'(bif.cfg_err), 8'h01);
    tick();
    check("tgtA clear", 8'(bif.cfg_err), 8'h00);

    // Pause mid-FILL, then reset mid-SWAP
    set_cfg(4'd0, 4'd5, 4'd0, 4'd1);
    start_run();
    bif.pause = 1'b1;
    tick();
    check("pause valve", 8'(bif.valve_open), 8'h00);
    pill();
    check("paused count", {bif.nowH, bif.nowL}, 8'h01);
    bif.pause = 1'b0;
    tick();
    check("unpause valve", 8'(bif.valve_open), 8'h01);
    repeat (4) pill();
    check("pre-reset conv", 8'(bif.conveyor_req), 8'h01);
    #1;
    RST = 1'b1;
    #1;
    check_all_zero("async rst");
    model_reset();
    tick();
    RST = 1'b0;

`ifdef BOTTLE_TIMEOUT_EN
    // Timeout expiry and ack on the expiry cycle
    set_cfg(4'd0, 4'd1, 4'd0, 4'd2);
    start_run();
    pill();
    repeat (4) tick();
    check("to 4 no alarm", 8'(bif.alarm), 8'h00);
    tick();
    check("to 5 alarm", 8'(bif.alarm), 8'h01);
    bif.alarm_clr = 1'b1;
    tick();
    bif.alarm_clr = 1'b0;
    start_run();
    pill();
    repeat (4) tick();
    ack();
    check("to ack seq", {bif.seqH, bif.seqL}, 8'h01);
    check("to ack alarm", 8'(bif.alarm), 8'h00);
`endif

    // Randomized phase, model-checked every cycle
    for (int i = 0; i < 4000; i++) begin
      bif.start        = ($urandom % 6) == 0;
      bif.pause        = ($urandom % 5) == 0;
      bif.alarm_clr    = ($urandom % 6) == 0;
      bif.pill_pulse   = ($urandom % 3) == 0;
      bif.bottle_ready = ($urandom % 4) == 0;
      if (($urandom % 16) == 0) begin
        if (($urandom % 8) == 0) begin
          set_cfg(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end else begin
          int mx, tg;
          mx = int'($urandom_range(1, 15));
          tg = int'($urandom_range(1, 4));
          set_cfg(4'(mx / 10), 4'(mx % 10), 4'(tg / 10), 4'(tg % 10));
        end
      end
      tick();
    end

    @(negedge CLK);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
